// File: rtl/avalon_mm_burst_bridge_if.sv
// Avalon-MM command/response signal bundle used for both sides of avalon_mm_burst_bridge.
// The master modport drives commands; the slave modport drives backpressure and read responses.
interface avalon_mm_burst_bridge_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 24,
  parameter int BURST_W = 4
) ();
  logic [ADDR_W-1:0]   address;
  logic [BURST_W-1:0]  burstcount;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic                debugaccess;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, burstcount, read, write, writedata, byteenable, debugaccess,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, burstcount, read, write, writedata, byteenable, debugaccess,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/avalon_mm_burst_bridge.sv
// Avalon-MM pipeline bridge: registered command stage with skid buffer, outstanding-read limiter
// and sticky unexpected-response flag. Define AVMM_BRIDGE_RSP_REG_EN to register the read response.
module avalon_mm_burst_bridge #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 24,
  parameter int BURST_W     = 4,
  parameter int MAX_PENDING = 16
) (
  input  logic                      clk_clk,
  input  logic                      reset_reset,
  avalon_mm_burst_bridge_if.slave   s0,
  avalon_mm_burst_bridge_if.master  m0,
  output logic                      err_unexpected_rsp
);
  localparam int BE_W   = DATA_W / 8;
  localparam int PEND_W = $clog2(MAX_PENDING + 1);

  typedef struct packed {
    logic [ADDR_W-1:0]  address;
    logic [BURST_W-1:0] burstcount;
    logic               read;
    logic               write;
    logic [DATA_W-1:0]  writedata;
    logic [BE_W-1:0]    byteenable;
    logic               debugaccess;
  } cmd_t;

  cmd_t              s0_cmd;
  cmd_t              cmd_reg;
  cmd_t              skid_reg;
  logic              cmd_v_reg;
  logic              skid_v_reg;
  logic              skid_v_next;
  logic              wait_reg;
  logic [PEND_W-1:0] pend_reg;
  logic [PEND_W-1:0] pend_next;
  logic              err_reg;
  logic              accept;
  logic              read_ok;
  logic              rd_strobe;
  logic              wr_strobe;
  logic              retire;
  logic              rsp_counted;

  assign s0_cmd = '{address:     s0.address,
                    burstcount:  s0.burstcount,
                    read:        s0.read,
                    write:       s0.write,
                    writedata:   s0.writedata,
                    byteenable:  s0.byteenable,
                    debugaccess: s0.debugaccess};

  assign accept    = (s0.read | s0.write) & ~wait_reg;
  // A read only goes out if every beat it asks for still fits under the outstanding limit.
  assign read_ok   = (32'(pend_reg) + 32'(cmd_reg.burstcount)) <= 32'(MAX_PENDING);
  assign rd_strobe = cmd_v_reg & cmd_reg.read & read_ok;
  assign wr_strobe = cmd_v_reg & cmd_reg.write;
  assign retire    = (rd_strobe | wr_strobe) & ~m0.waitrequest;

  assign m0.read        = rd_strobe;
  assign m0.write       = wr_strobe;
  assign m0.address     = cmd_reg.address;
  assign m0.burstcount  = cmd_reg.burstcount;
  assign m0.writedata   = cmd_reg.writedata;
  assign m0.byteenable  = cmd_reg.byteenable;
  assign m0.debugaccess = cmd_reg.debugaccess;
  assign s0.waitrequest = wait_reg;

  // Skid only fills when a beat arrives while the main register is occupied and not leaving.
  assign skid_v_next = skid_v_reg ? ~retire : (accept & cmd_v_reg & ~retire);

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      cmd_v_reg  <= 1'b0;
      skid_v_reg <= 1'b0;
      wait_reg   <= 1'b1;
      cmd_reg    <= '0;
      skid_reg   <= '0;
    end else begin
      skid_v_reg <= skid_v_next;
      wait_reg   <= skid_v_next;
      if (skid_v_reg) begin
        if (retire) cmd_reg <= skid_reg;
      end else if (accept) begin
        if (!cmd_v_reg || retire) begin
          cmd_reg   <= s0_cmd;
          cmd_v_reg <= 1'b1;
        end else begin
          skid_reg <= s0_cmd;
        end
      end else if (retire) begin
        cmd_v_reg <= 1'b0;
      end
    end
  end

  assign rsp_counted = m0.readdatavalid & (pend_reg != '0);

  always_comb begin
    pend_next = pend_reg;
    if (rd_strobe && !m0.waitrequest) pend_next = pend_next + PEND_W'(cmd_reg.burstcount);
    if (rsp_counted) pend_next = pend_next - PEND_W'(1);
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      pend_reg <= '0;
      err_reg  <= 1'b0;
    end else begin
      pend_reg <= pend_next;
      if (m0.readdatavalid && pend_reg == '0) err_reg <= 1'b1;
    end
  end

  assign err_unexpected_rsp = err_reg;

`ifdef AVMM_BRIDGE_RSP_REG_EN
  logic [DATA_W-1:0] rdata_reg;
  logic              rvalid_reg;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      rdata_reg  <= '0;
      rvalid_reg <= 1'b0;
    end else begin
      rdata_reg  <= m0.readdata;
      rvalid_reg <= m0.readdatavalid;
    end
  end

  assign s0.readdata      = rdata_reg;
  assign s0.readdatavalid = rvalid_reg;
`else
  assign s0.readdata      = m0.readdata;
  assign s0.readdatavalid = m0.readdatavalid;
`endif
endmodule

// File: tb/tb_avalon_mm_burst_bridge.sv
// Self-checking bench for avalon_mm_burst_bridge: queue-based model of accepted beats and
// outstanding reads, checked every cycle, plus directed scenarios with literal expectations.
module tb_avalon_mm_burst_bridge;
  localparam int DATA_W      = 32;
  localparam int ADDR_W      = 24;
  localparam int BURST_W     = 4;
  localparam int MAX_PENDING = 16;
  localparam int MAX_BURST   = 1 << (BURST_W - 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic err;

  always #5 clk = ~clk;

  avalon_mm_burst_bridge_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W)) s0_bus ();
  avalon_mm_burst_bridge_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W)) m0_bus ();

  avalon_mm_burst_bridge #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W), .MAX_PENDING(MAX_PENDING)
  ) dut (
    .clk_clk            (clk),
    .reset_reset        (rst),
    .s0                 (s0_bus),
    .m0                 (m0_bus),
    .err_unexpected_rsp (err)
  );

  typedef struct {
    bit                 rd;
    bit                 wr;
    logic [ADDR_W-1:0]  addr;
    logic [BURST_W-1:0] bc;
    logic [DATA_W-1:0]  wd;
    logic [3:0]         be;
    bit                 dbg;
  } cmd_t;

  cmd_t              drv;
  cmd_t              exp_q[$];
  logic [ADDR_W-1:0] ret_log[$];
  int                pend_m;
  bit                err_m;
  bit                prev_rdv;
  logic [DATA_W-1:0] prev_rdata;
  bit                m_wait;
  bit                m_rdv;
  logic [DATA_W-1:0] m_rdata;
  bit                acc;
  int                errors = 0;
  int                checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    drv.rd = 1'b0;
    drv.wr = 1'b0;
  endtask

  task automatic set_cmd(input bit rd, input bit wr, input logic [ADDR_W-1:0] a, input int bc,
                         input logic [DATA_W-1:0] wd);
    drv.rd   = rd;
    drv.wr   = wr;
    drv.addr = a;
    drv.bc   = BURST_W'(bc);
    drv.wd   = wd;
    drv.be   = 4'hF;
    drv.dbg  = 1'b0;
  endtask

  function automatic bit busy();
    return (drv.rd || drv.wr) && !acc;
  endfunction

  // One clock: drive inputs, compare every output with the model, then advance the model
  // by what the coming clock edge must do.
  task automatic step();
    cmd_t h;
    bit   exp_rd;
    bit   exp_wr;
    bit   ret;
    int   inc;
    int   old;
    @(negedge clk);
    s0_bus.read           = drv.rd;
    s0_bus.write          = drv.wr;
    s0_bus.address        = drv.addr;
    s0_bus.burstcount     = drv.bc;
    s0_bus.writedata      = drv.wd;
    s0_bus.byteenable     = drv.be;
    s0_bus.debugaccess    = drv.dbg;
    m0_bus.waitrequest    = m_wait;
    m0_bus.readdatavalid  = m_rdv;
    m0_bus.readdata       = m_rdata;
    #1;
    chk("s0_waitrequest", s0_bus.waitrequest, exp_q.size() >= 2);
    exp_rd = 1'b0;
    exp_wr = 1'b0;
    if (exp_q.size() > 0) begin
      h      = exp_q[0];
      exp_wr = h.wr;
      exp_rd = h.rd && (pend_m + int'(h.bc) <= MAX_PENDING);
      chk("m0_address", m0_bus.address, h.addr);
      chk("m0_burstcount", m0_bus.burstcount, h.bc);
      chk("m0_writedata", m0_bus.writedata, h.wd);
      chk("m0_byteenable", m0_bus.byteenable, h.be);
      chk("m0_debugaccess", m0_bus.debugaccess, h.dbg);
    end
    chk("m0_read", m0_bus.read, exp_rd);
    chk("m0_write", m0_bus.write, exp_wr);
`ifdef AVMM_BRIDGE_RSP_REG_EN
    chk("s0_readdatavalid", s0_bus.readdatavalid, prev_rdv);
    if (prev_rdv) chk("s0_readdata", s0_bus.readdata, prev_rdata);
`else
    chk("s0_readdatavalid", s0_bus.readdatavalid, m_rdv);
    if (m_rdv) chk("s0_readdata", s0_bus.readdata, m_rdata);
`endif
    chk("err_unexpected_rsp", err, err_m);

    acc = (drv.rd || drv.wr) && !s0_bus.waitrequest;
    ret = (m0_bus.read || m0_bus.write) && !m_wait;
    old = pend_m;
    inc = 0;
    if (ret) begin
      if (exp_q.size() == 0) begin
        chk("spurious_m0_cmd", 1'b1, 1'b0);
      end else begin
        if (exp_q[0].rd) inc = int'(exp_q[0].bc);
        ret_log.push_back(exp_q[0].addr);
        void'(exp_q.pop_front());
      end
    end
    if (acc) exp_q.push_back(drv);
    if (m_rdv && old == 0) err_m = 1'b1;
    pend_m     = old + inc - ((m_rdv && old > 0) ? 1 : 0);
    prev_rdv   = m_rdv;
    prev_rdata = m_rdata;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    idle();
    m_wait = 1'b0;
    m_rdv  = 1'b0;
    m_rdata = '0;
    s0_bus.read          = 1'b0;
    s0_bus.write         = 1'b0;
    m0_bus.readdatavalid = 1'b0;
    m0_bus.readdata      = '0;
    m0_bus.waitrequest   = 1'b0;
    #1;
    chk("rst_s0_waitrequest", s0_bus.waitrequest, 1'b1);
    chk("rst_m0_read", m0_bus.read, 1'b0);
    chk("rst_m0_write", m0_bus.write, 1'b0);
    chk("rst_m0_address", m0_bus.address, 0);
    chk("rst_m0_burstcount", m0_bus.burstcount, 0);
    chk("rst_m0_writedata", m0_bus.writedata, 0);
    chk("rst_m0_byteenable", m0_bus.byteenable, 0);
    chk("rst_m0_debugaccess", m0_bus.debugaccess, 0);
    chk("rst_s0_readdatavalid", s0_bus.readdatavalid, 1'b0);
    chk("rst_s0_readdata", s0_bus.readdata, 0);
    chk("rst_err", err, 1'b0);
    exp_q.delete();
    pend_m     = 0;
    err_m      = 1'b0;
    prev_rdv   = 1'b0;
    prev_rdata = '0;
    acc        = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_release_waitrequest", s0_bus.waitrequest, 1'b1);
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (i < 400 && (exp_q.size() > 0 || pend_m > 0 || busy())) begin
      if (!busy()) idle();
      m_wait = 1'b0;
      m_rdv  = (pend_m > 0);
      m_rdata = $urandom;
      step();
      i++;
    end
    idle();
    m_rdv = 1'b0;
    chk("drain_done", (exp_q.size() > 0 || pend_m > 0), 1'b0);
  endtask

  initial begin
    bit wait_tab[8];
    bit wreq_tab[8];
    int beat;
    int wr_left;
    wait_tab = '{0, 1, 1, 0, 0, 0, 0, 0};
    wreq_tab = '{0, 0, 1, 1, 0, 0, 0, 0};
    s0_bus.address = '0; s0_bus.burstcount = '0; s0_bus.read = 1'b0; s0_bus.write = 1'b0;
    s0_bus.writedata = '0; s0_bus.byteenable = '0; s0_bus.debugaccess = 1'b0;
    m0_bus.waitrequest = 1'b0; m0_bus.readdata = '0; m0_bus.readdatavalid = 1'b0;
    drv = '{rd: 1'b0, wr: 1'b0, addr: '0, bc: '0, wd: '0, be: '0, dbg: 1'b0};

    // single write, 1-cycle command latency
    do_reset();
    set_cmd(1'b0, 1'b1, 24'h000010, 1, 32'hDEADBEEF);
    step();
    chk("t1_accept", acc, 1'b1);
    idle();
    step();
    chk("t1_m0_write", m0_bus.write, 1'b1);
    chk("t1_m0_address", m0_bus.address, 24'h000010);
    chk("t1_m0_writedata", m0_bus.writedata, 32'hDEADBEEF);
    chk("t1_s0_waitrequest", s0_bus.waitrequest, 1'b0);
    step();
    chk("t1_m0_write_done", m0_bus.write, 1'b0);

    // four back-to-back writes with m0 backpressure in cycles 2-3
    ret_log.delete();
    beat = 0;
    for (int s = 0; s < 8; s++) begin
      if (beat < 4) set_cmd(1'b0, 1'b1, ADDR_W'(32'h100 + 4 * beat), 1, DATA_W'(32'hA0 + beat));
      else idle();
      m_wait = wait_tab[s];
      step();
      chk("t2_s0_waitrequest", s0_bus.waitrequest, wreq_tab[s]);
      if (acc && beat < 4) beat++;
    end
    chk("t2_beat_count", ret_log.size(), 4);
    for (int i = 0; i < 4 && i < ret_log.size(); i++)
      chk("t2_beat_order", ret_log[i], 32'h100 + 4 * i);
    m_wait = 1'b0;

    // outstanding-read limit: third 8-beat burst waits for 8 responses
    for (int k = 0; k < 3; k++) begin
      set_cmd(1'b1, 1'b0, ADDR_W'(32'h200 + 32 * k), 8, '0);
      step();
      chk("t3_accept", acc, 1'b1);
    end
    idle();
    step();
    chk("t3_held", m0_bus.read, 1'b0);
    step();
    chk("t3_held", m0_bus.read, 1'b0);
    for (int k = 0; k < 8; k++) begin
      m_rdv = 1'b1;
      m_rdata = $urandom;
      step();
      chk("t3_held_during_rsp", m0_bus.read, 1'b0);
    end
    m_rdv = 1'b0;
    step();
    chk("t3_issue", m0_bus.read, 1'b1);
    step();
    chk("t3_pend_full", dut.pend_reg, 16);
    drain();

    // read retire (4 beats) coinciding with a response at pend=3
    set_cmd(1'b1, 1'b0, 24'h000300, 3, '0);
    step();
    idle();
    step();
    set_cmd(1'b1, 1'b0, 24'h000304, 4, '0);
    step();
    chk("t4_pend_before", dut.pend_reg, 3);
    idle();
    m_rdv = 1'b1;
    step();
    m_rdv = 1'b0;
    step();
    chk("t4_pend_net", dut.pend_reg, 6);

    // read response latency
    m_rdata = 32'h12345678;
    m_rdv = 1'b1;
    step();
    m_rdv = 1'b0;
    m_rdata = 32'h0;
`ifdef AVMM_BRIDGE_RSP_REG_EN
    chk("t6_valid_cycle_n", s0_bus.readdatavalid, 1'b0);
    step();
    chk("t6_valid_cycle_n1", s0_bus.readdatavalid, 1'b1);
    chk("t6_data_cycle_n1", s0_bus.readdata, 32'h12345678);
`else
    chk("t6_valid_cycle_n", s0_bus.readdatavalid, 1'b1);
    chk("t6_data_cycle_n", s0_bus.readdata, 32'h12345678);
    step();
    chk("t6_valid_cycle_n1", s0_bus.readdatavalid, 1'b0);
`endif
    drain();

    // unexpected response, sticky flag, and late response after reset
    m_rdv = 1'b1;
    step();
    m_rdv = 1'b0;
    step();
    chk("t5_err_set", err, 1'b1);
    repeat (3) step();
    chk("t5_err_sticky", err, 1'b1);
    set_cmd(1'b1, 1'b0, 24'h000400, 2, '0);
    step();
    idle();
    step();
    step();
    do_reset();
    m_rdv = 1'b1;
    step();
    m_rdv = 1'b0;
    step();
    chk("t5_late_rsp_err", err, 1'b1);
    do_reset();

    // randomized traffic against the model
    wr_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!busy()) begin
        if (wr_left > 0) begin
          drv.wd = $urandom;
          drv.be = 4'($urandom);
          wr_left--;
        end else if ($urandom_range(0, 3) == 0) begin
          idle();
        end else begin
          drv.addr = ADDR_W'($urandom);
          drv.bc   = BURST_W'($urandom_range(1, MAX_BURST));
          drv.wd   = $urandom;
          drv.be   = 4'($urandom);
          drv.dbg  = 1'($urandom);
          if ($urandom_range(0, 1) == 1) begin
            drv.rd = 1'b1;
            drv.wr = 1'b0;
          end else begin
            drv.rd = 1'b0;
            drv.wr = 1'b1;
            wr_left = int'(drv.bc) - 1;
          end
        end
      end
      m_wait  = ($urandom_range(0, 3) == 0);
      m_rdv   = (pend_m > 0) && ($urandom_range(0, 2) != 0);
      m_rdata = $urandom;
      step();
    end
    drain();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
